// File: rtl/note_scheduler.sv
// note_scheduler: walks a chart ROM row by row, paces rows by a tick-based delay
// and serialises each row's lane mask into one spawn per clock; also runs time_.
module note_scheduler #(
  parameter int TICK_DIV = 100000,
  parameter int ADDR_W   = 8,
  parameter int DELTA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               wait_,
  input  logic               hold,
  input  logic               speed,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DELTA_W+3:0] rom_data,
  output logic               out_valid,
  output logic [1:0]         drop_pos,
  output logic               on_off,
  output logic [8:0]         time_,
  output logic               busy,
  output logic               done
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]   FULL_M1    = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0]   HALF_M1    = DIV_W'(TICK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = '1;
  localparam logic [DELTA_W-1:0] DELTA_ONE  = DELTA_W'(1);
  localparam logic [8:0]         TIME_MAX   = 9'd479;

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, COUNT, DONE} state_t;

  state_t             state_reg;
  logic [DIV_W-1:0]   div_reg;
  logic               fast_reg;
  logic [3:0]         mask_reg;
  logic [DELTA_W-1:0] delta_reg;
  logic [DELTA_W-1:0] cnt_reg;

  logic               fast_sel;
  logic [DIV_W-1:0]   div_lim;
  logic               tick;
  logic [3:0]         cur_mask;
  logic [DELTA_W-1:0] cur_delta;
  logic [3:0]         low_hot;
  logic [3:0]         rest_mask;
  logic [1:0]         low_idx;

  // Speed is only sampled while the divider sits at zero, so a change made
  // mid-period applies from the following period.
  assign fast_sel = (div_reg == '0) ? speed : fast_reg;
  assign div_lim  = fast_sel ? HALF_M1 : FULL_M1;
  assign tick     = on_off && !hold && (div_reg == div_lim);

  // The first spawn of a row is issued straight from the ROM word in LATCH,
  // later spawns come from the remaining mask held in ISSUE.
  assign cur_mask  = (state_reg == LATCH) ? rom_data[3:0] : mask_reg;
  assign cur_delta = (state_reg == LATCH) ? rom_data[DELTA_W+3:4] : delta_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_low
    if (gi == 0) begin : g_first
      assign low_hot[gi] = cur_mask[0];
    end else begin : g_rest
      assign low_hot[gi] = cur_mask[gi] & ~(|cur_mask[gi-1:0]);
    end
  end

  assign rest_mask = cur_mask & ~low_hot;
  assign low_idx   = {low_hot[3] | low_hot[2], low_hot[3] | low_hot[1]};

  always_ff @(posedge clk) begin
    if (rst || wait_) begin
      state_reg <= IDLE;
      rom_addr  <= '0;
      time_     <= '0;
      div_reg   <= '0;
      fast_reg  <= 1'b0;
      mask_reg  <= '0;
      delta_reg <= '0;
      cnt_reg   <= '0;
      out_valid <= 1'b0;
      drop_pos  <= 2'd0;
      on_off    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (hold) begin
      // Everything freezes; strobes are dropped so they never stretch.
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      fast_reg  <= fast_sel;
      if (on_off) begin
        div_reg <= tick ? '0 : div_reg + DIV_ONE;
      end
      if (tick) begin
        time_ <= (time_ == TIME_MAX) ? '0 : time_ + 9'd1;
      end

      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg <= FETCH;
            rom_addr  <= '0;
            time_     <= '0;
            on_off    <= 1'b1;
            busy      <= 1'b1;
          end
        end

        FETCH: state_reg <= LATCH;

        LATCH, ISSUE: begin
          if (state_reg == LATCH) begin
            delta_reg <= cur_delta;
          end
          if (cur_mask == 4'd0) begin
            state_reg <= DONE;
            on_off    <= 1'b0;
            done      <= 1'b1;
          end else begin
            out_valid <= 1'b1;
            drop_pos  <= low_idx;
            mask_reg  <= rest_mask;
            if (rest_mask != 4'd0) begin
              state_reg <= ISSUE;
            end else if (rom_addr == LAST_ADDR) begin
              state_reg <= DONE;
              on_off    <= 1'b0;
              done      <= 1'b1;
            end else begin
              rom_addr <= rom_addr + ADDR_ONE;
              if (cur_delta == '0) begin
                state_reg <= FETCH;
              end else begin
                state_reg <= COUNT;
                cnt_reg   <= cur_delta;
              end
            end
          end
        end

        COUNT: begin
          if (tick) begin
            cnt_reg <= cnt_reg - DELTA_ONE;
            if (cnt_reg == DELTA_ONE) begin
              state_reg <= FETCH;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
